au_result_fifo: RTL
===================

AU_RESULT_FIFO -- requirements
Module: au_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  producer presents an arithmetic-unit result.
REQ-005 SHALL have port in_ready  output  1  FIFO accepts an entry this cycle.
REQ-006 SHALL have port in_result  input  8  signed arithmetic-unit Result.
REQ-007 SHALL have port in_op  input  2  Op that produced the result (00 add, 01 sub, 10 compare, 11 absdiff).
REQ-008 SHALL have port in_flags  input  3  {Overflow, Zero, Negative}.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-011 SHALL have port out_result  output  8  signed head result.
REQ-012 SHALL have port out_op  output  2  head Op.
REQ-013 SHALL have port out_flags  output  3  head {Overflow, Zero, Negative}.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port sticky_ovf  output  1  an accepted entry has carried Overflow=1 since the last clear.
REQ-016 SHALL have port clr_sticky  input  1  synchronous clear of sticky status.

Function
REQ-017 SHALL push on a cycle when in_valid && in_ready, and pop on a cycle when out_valid && out_ready.
REQ-018 SHALL drive in_ready = (count != DEPTH). When full, the FIFO SHALL NOT accept a push, even if a pop occurs in the same cycle.
REQ-019 SHALL drive out_valid = (count != 0). out_* SHALL come from registered storage at the read pointer, with no bypass. An entry pushed into an empty FIFO SHALL appear on out_* on the next cycle (latency 1).
REQ-020 SHALL hold out_result, out_op and out_flags stable while out_valid && !out_ready.
REQ-021 SHALL leave count unchanged on a simultaneous push and pop; the FIFO SHALL be non-empty and non-full in that case.
REQ-022 SHALL wrap read and write pointers modulo DEPTH. Order SHALL be strictly FIFO.
REQ-023 SHALL treat a pop when empty as a no-op; out_* are don't-care when out_valid=0.
REQ-024 SHALL set sticky_ovf the cycle after a push with in_flags[2]=1.
REQ-025 SHALL clear sticky_ovf when clr_sticky=1. If a set and a clear occur in the same cycle, the set SHALL win.
REQ-026 SHALL store in_result unmodified as 8-bit two's complement, with no saturation or sign correction.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force pointers=0, count=0, out_valid=0, in_ready=1, sticky_ovf=0, and ovf_count=0 when present.
REQ-028 SHALL discard all stored entries on reset mid-operation; the first push after rst_n deasserts SHALL be the next output.

Configuration
REQ-029 SHALL compile an overflow event counter when AU_OVF_COUNT_EN is defined. This adds port ovf_count  output  8, which increments on each push with in_flags[2]=1, saturates at 255, and clears with clr_sticky (increment wins on simultaneous events).
REQ-030 SHALL have no ovf_count port or logic when AU_OVF_COUNT_EN is undefined; all other behaviour SHALL be identical.

Structure
REQ-031 SHALL take the Op encodings (OP_ADD=00, OP_SUB=01, OP_CMP=10, OP_ABS=11), the flag bit indices (FLG_OVF=2, FLG_ZERO=1, FLG_NEG=0) and a packed 13-bit entry typedef {result, op, flags} from shared package au_pkg.
REQ-032 SHALL be implemented as a single module with no sub-module; storage SHALL be a DEPTH x 13 register array.

Verification
REQ-033 SHALL cover this case: push {120, 00, 000} into an empty FIFO, out_ready=1 -> out_valid=1 one cycle later with out_result=120, then empty.
REQ-034 SHALL cover this case: push {-106, 00, 100} (100+50 overflow) -> sticky_ovf=1 next cycle; clr_sticky pulse -> sticky_ovf=0; set and clear in the same cycle -> sticky_ovf=1.
REQ-035 SHALL cover this case: out_ready=0, push 4 entries {120, -20, 0, 20} -> count=4, in_ready=0; a 5th push with in_valid=1 is dropped; drain -> outputs appear in order 120, -20, 0, 20.
REQ-036 SHALL cover this case: FIFO at count=2 with push and pop in the same cycle, repeated for 10 cycles -> count stays 2, pointers wrap, order preserved.
REQ-037 SHALL cover this case: rst_n asserted with count=3 -> count=0, out_valid=0 immediately, without waiting for a clock edge.
REQ-038 SHALL cover this case: with AU_OVF_COUNT_EN, 300 pushes with Overflow=1 -> ovf_count=255.

Source files
------------

// File: rtl/au_pkg.sv
// Shared arithmetic-unit definitions: op encodings, flag bit positions and the result entry layout.
package au_pkg;

   localparam int unsigned RESULT_W = 8;
   localparam int unsigned OP_W     = 2;
   localparam int unsigned FLAGS_W  = 3;
   localparam int unsigned ENTRY_W  = RESULT_W + OP_W + FLAGS_W;

   localparam logic [OP_W-1:0] OP_ADD = 2'b00;
   localparam logic [OP_W-1:0] OP_SUB = 2'b01;
   localparam logic [OP_W-1:0] OP_CMP = 2'b10;
   localparam logic [OP_W-1:0] OP_ABS = 2'b11;

   localparam int unsigned FLG_OVF  = 2;
   localparam int unsigned FLG_ZERO = 1;
   localparam int unsigned FLG_NEG  = 0;

   typedef struct packed {
      logic [RESULT_W-1:0] result;
      logic [OP_W-1:0]     op;
      logic [FLAGS_W-1:0]  flags;
   } au_entry_t;

endpackage

// File: rtl/au_result_fifo.sv
// Result FIFO for the arithmetic unit: DEPTH x 13-bit entries, sticky overflow status.
// Optional feature: define AU_OVF_COUNT_EN to add the saturating 8-bit ovf_count output.
module au_result_fifo
   import au_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [RESULT_W-1:0]        in_result,
   input  logic [OP_W-1:0]            in_op,
   input  logic [FLAGS_W-1:0]         in_flags,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [RESULT_W-1:0]        out_result,
   output logic [OP_W-1:0]            out_op,
   output logic [FLAGS_W-1:0]         out_flags,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       sticky_ovf,
   input  logic                       clr_sticky
`ifdef AU_OVF_COUNT_EN
   ,
   output logic [7:0]                 ovf_count
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   au_entry_t        mem [DEPTH];
   au_entry_t        wr_entry;
   au_entry_t        head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic             ovf_event;

   // Handshake decode; a full FIFO refuses pushes even when popping the same cycle.
   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign ovf_event = push && in_flags[FLG_OVF];

   assign wr_entry = '{result: in_result, op: in_op, flags: in_flags};

   // Head entry comes straight from storage at the read pointer, no bypass.
   assign head       = mem[rd_ptr];
   assign out_result = head.result;
   assign out_op     = head.op;
   assign out_flags  = head.flags;

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // Pointers wrap naturally at the power-of-two DEPTH; occupancy tracks push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow; a new overflow push beats a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_ovf <= 1'b0;
      end else if (ovf_event) begin
         sticky_ovf <= 1'b1;
      end else if (clr_sticky) begin
         sticky_ovf <= 1'b0;
      end
   end

`ifdef AU_OVF_COUNT_EN
   // Saturating overflow event counter; increment beats a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_count <= '0;
      end else if (ovf_event) begin
         if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
      end else if (clr_sticky) begin
         ovf_count <= '0;
      end
   end
`endif

endmodule
